// File: rtl/sum_acc_pkg.sv
// ---------------------------------------------------------------------------
// sum_acc_pkg
// Shared definitions for the sum_accumulator block.
//   state_t        : accumulator control states (IDLE, ACCUM, HOLD)
//   DEF_WIDTH      : default width of the upstream adder sum
//   DEF_ACC_WIDTH  : default accumulator width
//   DEF_COUNT      : default number of samples folded into one result
//   CNT_WIDTH      : width of the sample counter
// ---------------------------------------------------------------------------
package sum_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_ACC_WIDTH = 16;
   localparam int DEF_COUNT     = 4;
   localparam int CNT_WIDTH     = 8;

endpackage

// File: rtl/adder_cla.sv
// ---------------------------------------------------------------------------
// adder_cla
// WIDTH-bit carry-lookahead adder. Bits are split into 4-bit groups; each
// group produces a group generate/propagate pair, and the group carries are
// resolved by the lookahead chain. Carries inside a group are derived from
// that group's carry-in.
//   a, b  : addends (WIDTH bits)
//   cin   : carry into bit 0
//   sum   : a + b + cin, modulo 2^WIDTH
//   cout  : carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module adder_cla #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NGRP = (WIDTH + 3) / 4;

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [NGRP-1:0]  grp_g;
   logic [NGRP-1:0]  grp_p;
   logic [NGRP:0]    grp_c;

   assign g = a & b;
   assign p = a ^ b;

   genvar gi;
   generate
      for (gi = 0; gi < NGRP; gi++) begin : g_grp
         // The last group is narrower when WIDTH is not a multiple of 4.
         localparam int LO = gi * 4;
         localparam int N  = ((LO + 4) <= WIDTH) ? 4 : (WIDTH - LO);

         logic [N-1:0] c_l;
         logic         gg;
         logic         pp;

         // Group generate / propagate.
         always_comb begin
            gg = 1'b0;
            pp = 1'b1;
            for (int k = 0; k < N; k++) begin
               gg = g[LO+k] | (p[LO+k] & gg);
               pp = pp & p[LO+k];
            end
         end

         assign grp_g[gi] = gg;
         assign grp_p[gi] = pp;

         // Per-bit carries within the group, seeded by the group carry-in.
         always_comb begin
            c_l    = '0;
            c_l[0] = grp_c[gi];
            for (int k = 0; k < N - 1; k++) begin
               c_l[k+1] = g[LO+k] | (p[LO+k] & c_l[k]);
            end
         end

         assign sum[LO +: N] = p[LO +: N] ^ c_l;
      end
   endgenerate

   // Lookahead across groups kept in one process so the carry vector has a
   // single driver.
   always_comb begin
      grp_c    = '0;
      grp_c[0] = cin;
      for (int j = 0; j < NGRP; j++) begin
         grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      end
   end

   assign cout = grp_c[NGRP];

endmodule

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
// Folds COUNT samples of {carry_out, sum} from an upstream adder into one
// ACC_WIDTH-bit result and presents it on a valid/ready output.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : upstream sample valid
//   in_ready      : block can accept a sample (low while a result is held)
//   sum           : upstream adder sum (WIDTH bits)
//   carry_out     : upstream adder carry
//   clear         : synchronous abort of the current accumulation
//   acc_valid     : result valid
//   acc_ready     : downstream accepts the result
//   acc_data      : accumulator register (meaningful while acc_valid)
//   acc_overflow  : sticky, accumulator wrapped during this result
//   sample_cnt    : samples taken into the current result
// ACC_WIDTH must be at least WIDTH+1; COUNT must be in 1..255.
// ---------------------------------------------------------------------------
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int COUNT     = DEF_COUNT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     sum,
   input  logic                 carry_out,
   input  logic                 clear,
   output logic                 acc_valid,
   input  logic                 acc_ready,
   output logic [ACC_WIDTH-1:0] acc_data,
   output logic                 acc_overflow,
   output logic [CNT_WIDTH-1:0] sample_cnt
);

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;

   logic [ACC_WIDTH-1:0]   sample_ext;
   logic [ACC_WIDTH-1:0]   add_sum;
   logic                   add_cout;
   logic [CNT_WIDTH-1:0]   cnt_inc;

   // The upstream carry becomes the sample MSB; the rest is zero padding.
   assign sample_ext = ACC_WIDTH'({carry_out, sum});
   assign cnt_inc    = cnt_q + 1'b1;

   adder_cla #(
      .WIDTH (ACC_WIDTH)
   ) u_add (
      .a    (acc_q),
      .b    (sample_ext),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      if (clear) begin
         // Abort wins over any same-cycle sample or result handshake.
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // First sample loads rather than adds, so the previous
                  // result (still visible on acc_data) is discarded here.
                  acc_d   = sample_ext;
                  cnt_d   = CNT_WIDTH'(1);
                  ovf_d   = 1'b0;
                  state_d = (COUNT == 1) ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc_d = add_sum;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | add_cout;
                  if (cnt_inc == CNT_WIDTH'(COUNT)) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               // Samples are refused in the release cycle; the next one is
               // taken from IDLE.
               if (acc_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      in_ready  = 1'b0;
      acc_valid = 1'b0;
      unique case (state_q)
         IDLE, ACCUM: in_ready  = 1'b1;
         HOLD:        acc_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            acc_valid = 1'b0;
         end
      endcase
   end

   assign acc_data     = acc_q;
   assign acc_overflow = ovf_q;
   assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
// Three instances share one stimulus stream:
//   dut_m : WIDTH=8, ACC_WIDTH=16, COUNT=4
//   dut_w : WIDTH=8, ACC_WIDTH=10, COUNT=4
//   dut_c : WIDTH=8, ACC_WIDTH=16, COUNT=1
// A vector table and hand sequences cover the directed cases; a random phase
// compares every instance against a transaction-level model that tracks the
// samples of the current result as a plain integer total.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  sum = '0;
   logic        carry_out = 1'b0;
   logic        clear = 1'b0;
   logic        acc_ready = 1'b0;

   logic        m_in_ready, m_acc_valid, m_ovf;
   logic [15:0] m_data;
   logic [7:0]  m_cnt;
   logic        w_in_ready, w_acc_valid, w_ovf;
   logic [9:0]  w_data;
   logic [7:0]  w_cnt;
   logic        c_in_ready, c_acc_valid, c_ovf;
   logic [15:0] c_data;
   logic [7:0]  c_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sum_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) dut_m (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
      .sum(sum), .carry_out(carry_out), .clear(clear),
      .acc_valid(m_acc_valid), .acc_ready(acc_ready), .acc_data(m_data),
      .acc_overflow(m_ovf), .sample_cnt(m_cnt)
   );

   sum_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .COUNT(4)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
      .sum(sum), .carry_out(carry_out), .clear(clear),
      .acc_valid(w_acc_valid), .acc_ready(acc_ready), .acc_data(w_data),
      .acc_overflow(w_ovf), .sample_cnt(w_cnt)
   );

   sum_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(1)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
      .sum(sum), .carry_out(carry_out), .clear(clear),
      .acc_valid(c_acc_valid), .acc_ready(acc_ready), .acc_data(c_data),
      .acc_overflow(c_ovf), .sample_cnt(c_cnt)
   );

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      bit          full;   // a finished result is waiting for acc_ready
      bit          done;   // last result has left; next sample starts fresh
      int unsigned total;  // exact integer sum of the current result
      int unsigned cnt;
   } model_t;

   model_t mdl_m, mdl_w, mdl_c;

   function automatic model_t model_next(model_t m, bit r, bit c, bit v,
                                         int unsigned smp, bit ar,
                                         int unsigned count);
      model_t n = m;
      if (r || c) begin
         n.full = 0; n.done = 0; n.total = 0; n.cnt = 0;
      end else if (m.full) begin
         if (ar) begin
            n.full = 0; n.done = 1;
         end
      end else if (v) begin
         if (m.done) begin
            n.total = smp; n.cnt = 1; n.done = 0;
         end else begin
            n.total = m.total + smp; n.cnt = m.cnt + 1;
         end
         if (n.cnt == count) n.full = 1;
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic chk_model(input string tag, input model_t m,
                            input int acc_w, input logic vld,
                            input logic rdy, input logic [15:0] data,
                            input logic ovf, input logic [7:0] cnt);
      int unsigned mask = (32'd1 << acc_w) - 1;
      chk({tag, ".acc_valid"}, 32'(vld), 32'(m.full));
      chk({tag, ".in_ready"}, 32'(rdy), 32'(!m.full));
      chk({tag, ".acc_data"}, 32'(data), m.total & mask);
      chk({tag, ".acc_overflow"}, 32'(ovf), 32'((m.total >> acc_w) != 0));
      chk({tag, ".sample_cnt"}, 32'(cnt), m.cnt);
   endtask

   // Apply one cycle of inputs, advance the models, sample #1 after the edge.
   task automatic drive_cycle(input bit r, input bit c, input bit v,
                              input bit co, input logic [7:0] s,
                              input bit ar);
      int unsigned smp;
      rst = r; clear = c; in_valid = v; carry_out = co; sum = s;
      acc_ready = ar;
      smp = {23'd0, co, s};
      @(posedge clk);
      mdl_m = model_next(mdl_m, r, c, v, smp, ar, 4);
      mdl_w = model_next(mdl_w, r, c, v, smp, ar, 4);
      mdl_c = model_next(mdl_c, r, c, v, smp, ar, 1);
      #1;
   endtask

   // ---------------- directed vector table (main instance) ----------------
   typedef struct {
      bit rst, clr, vld, co;
      logic [7:0] s;
      bit ar;
      bit e_valid, e_ready;
      logic [15:0] e_data;
      bit e_ovf;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, bit c, bit v, bit co, logic [7:0] s,
                               bit ar, bit ev, bit er, logic [15:0] ed,
                               bit eo, logic [7:0] ec);
      vec_t t;
      t.rst = r; t.clr = c; t.vld = v; t.co = co; t.s = s; t.ar = ar;
      t.e_valid = ev; t.e_ready = er; t.e_data = ed; t.e_ovf = eo;
      t.e_cnt = ec;
      return t;
   endfunction

   initial begin
      mdl_m = '{0, 0, 0, 0};
      mdl_w = '{0, 0, 0, 0};
      mdl_c = '{0, 0, 0, 0};

      //                 rst clr v co  s    ar | vld rdy data     ovf cnt
      tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0,  0, 1, 16'h0000, 0, 0));
      // four samples {1,0xFF}
      tbl.push_back(mk(0, 0, 1, 1, 8'hFF, 0,  0, 1, 16'h01FF, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 8'hFF, 0,  0, 1, 16'h03FE, 0, 2));
      tbl.push_back(mk(0, 0, 1, 1, 8'hFF, 0,  0, 1, 16'h05FD, 0, 3));
      tbl.push_back(mk(0, 0, 1, 1, 8'hFF, 0,  1, 0, 16'h07FC, 0, 4));
      // five cycles of backpressure with a sample offered
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 0, 1, 0, 8'h22, 0,  1, 0, 16'h07FC, 0, 4));
      // release: sample in the same cycle is refused
      tbl.push_back(mk(0, 0, 1, 0, 8'h22, 1,  0, 1, 16'h07FC, 0, 4));
      // two samples, then clear with a third
      tbl.push_back(mk(0, 0, 1, 0, 8'h10, 0,  0, 1, 16'h0010, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 8'h10, 0,  0, 1, 16'h0020, 0, 2));
      tbl.push_back(mk(0, 1, 1, 0, 8'h10, 0,  0, 1, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h10, 0,  0, 1, 16'h0010, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 8'h10, 0,  0, 1, 16'h0020, 0, 2));
      tbl.push_back(mk(0, 0, 1, 0, 8'h10, 0,  0, 1, 16'h0030, 0, 3));
      tbl.push_back(mk(0, 0, 1, 0, 8'h10, 0,  1, 0, 16'h0040, 0, 4));
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1,  0, 1, 16'h0040, 0, 4));
      // idle cycle inside an accumulation holds state
      tbl.push_back(mk(0, 0, 1, 0, 8'h05, 0,  0, 1, 16'h0005, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0,  0, 1, 16'h0005, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 8'h07, 0,  0, 1, 16'h000C, 0, 2));
      tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0,  0, 1, 16'h0000, 0, 0));
      // reset after two samples, with clear and handshakes also active
      tbl.push_back(mk(0, 0, 1, 0, 8'h01, 0,  0, 1, 16'h0001, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 8'h01, 0,  0, 1, 16'h0002, 0, 2));
      tbl.push_back(mk(1, 1, 1, 0, 8'h01, 1,  0, 1, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h01, 0,  0, 1, 16'h0001, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 8'h01, 0,  0, 1, 16'h0002, 0, 2));
      tbl.push_back(mk(0, 0, 1, 0, 8'h01, 0,  0, 1, 16'h0003, 0, 3));
      tbl.push_back(mk(0, 0, 1, 0, 8'h01, 0,  1, 0, 16'h0004, 0, 4));
      // clear overrides a same-cycle result handshake
      tbl.push_back(mk(0, 1, 1, 0, 8'h01, 1,  0, 1, 16'h0000, 0, 0));

      foreach (tbl[i]) begin
         drive_cycle(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].co,
                     tbl[i].s, tbl[i].ar);
         chk($sformatf("tbl%0d.acc_valid", i), 32'(m_acc_valid),
             32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d.in_ready", i), 32'(m_in_ready),
             32'(tbl[i].e_ready));
         chk($sformatf("tbl%0d.acc_data", i), 32'(m_data),
             32'(tbl[i].e_data));
         chk($sformatf("tbl%0d.acc_overflow", i), 32'(m_ovf),
             32'(tbl[i].e_ovf));
         chk($sformatf("tbl%0d.sample_cnt", i), 32'(m_cnt),
             32'(tbl[i].e_cnt));
      end

      // ---- ACC_WIDTH=10: four samples of 0x1FF wrap the accumulator ----
      drive_cycle(1, 0, 0, 0, 8'h00, 0);
      drive_cycle(0, 0, 1, 1, 8'hFF, 0);
      drive_cycle(0, 0, 1, 1, 8'hFF, 0);
      chk("w10.step2.acc_data", 32'(w_data), 32'h3FE);
      chk("w10.step2.acc_overflow", 32'(w_ovf), 32'd0);
      drive_cycle(0, 0, 1, 1, 8'hFF, 0);
      chk("w10.step3.acc_data", 32'(w_data), 32'h1FD);
      chk("w10.step3.acc_overflow", 32'(w_ovf), 32'd1);
      drive_cycle(0, 0, 1, 1, 8'hFF, 0);
      chk("w10.acc_data", 32'(w_data), 32'h3FC);
      chk("w10.acc_overflow", 32'(w_ovf), 32'd1);
      chk("w10.acc_valid", 32'(w_acc_valid), 32'd1);
      chk("w10.sample_cnt", 32'(w_cnt), 32'd4);
      // overflow stays set while the result is held
      drive_cycle(0, 0, 0, 0, 8'h00, 0);
      chk("w10.hold.acc_overflow", 32'(w_ovf), 32'd1);
      // a fresh result starts with the flag cleared
      drive_cycle(0, 0, 0, 0, 8'h00, 1);
      drive_cycle(0, 0, 1, 0, 8'h01, 0);
      chk("w10.fresh.acc_overflow", 32'(w_ovf), 32'd0);
      chk("w10.fresh.acc_data", 32'(w_data), 32'h001);

      // ---- COUNT=1: each sample is a complete result ----
      drive_cycle(1, 0, 0, 0, 8'h00, 0);
      chk("c1.reset.in_ready", 32'(c_in_ready), 32'd1);
      drive_cycle(0, 0, 1, 1, 8'h55, 0);
      chk("c1.acc_valid", 32'(c_acc_valid), 32'd1);
      chk("c1.acc_data", 32'(c_data), 32'h0155);
      chk("c1.sample_cnt", 32'(c_cnt), 32'd1);
      chk("c1.in_ready", 32'(c_in_ready), 32'd0);
      drive_cycle(0, 0, 1, 0, 8'h33, 0);
      chk("c1.blocked.acc_data", 32'(c_data), 32'h0155);
      drive_cycle(0, 0, 1, 0, 8'h33, 1);
      chk("c1.release.acc_valid", 32'(c_acc_valid), 32'd0);
      chk("c1.release.acc_data", 32'(c_data), 32'h0155);
      drive_cycle(0, 0, 1, 0, 8'h03, 0);
      chk("c1.next.acc_valid", 32'(c_acc_valid), 32'd1);
      chk("c1.next.acc_data", 32'(c_data), 32'h0003);

      // ---- randomized traffic against the models ----
      drive_cycle(1, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 3000; i++) begin
         drive_cycle($urandom_range(0, 199) == 0,
                     $urandom_range(0, 39) == 0,
                     $urandom_range(0, 9) < 7,
                     1'($urandom),
                     8'($urandom),
                     1'($urandom));
         chk_model("rnd.m", mdl_m, 16, m_acc_valid, m_in_ready, m_data,
                   m_ovf, m_cnt);
         chk_model("rnd.w", mdl_w, 10, w_acc_valid, w_in_ready,
                   16'(w_data), w_ovf, w_cnt);
         chk_model("rnd.c", mdl_c, 16, c_acc_valid, c_in_ready, c_data,
                   c_ovf, c_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the upstream adder sum.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: accumulator width; legal range is ACC_WIDTH >= WIDTH+1.
REQ-003 SHALL have parameter COUNT, default 4: samples per result; legal range is 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-008 SHALL have port sum, input, WIDTH bits: upstream adder sum.
REQ-009 SHALL have port carry_out, input, 1 bit: upstream adder carry.
REQ-010 SHALL have port clear, input, 1 bit: synchronous abort of the current accumulation.
REQ-011 SHALL have port acc_valid, output, 1 bit: result valid.
REQ-012 SHALL have port acc_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port acc_data, output, ACC_WIDTH bits: accumulated result.
REQ-014 SHALL have port acc_overflow, output, 1 bit: sticky flag, accumulator wrapped during this result.
REQ-015 SHALL have port sample_cnt, output, 8 bits: samples taken into the current result.

Function
REQ-016 Sample value SHALL be {carry_out, sum}, zero-extended to ACC_WIDTH bits.
REQ-017 A sample SHALL be accepted on a rising edge when in_valid && in_ready are both 1.
REQ-018 State machine SHALL have states IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD.
REQ-019 In IDLE, an accepted sample SHALL load acc = sample, set sample_cnt = 1 and clear acc_overflow; next state SHALL be HOLD if COUNT == 1, else ACCUM.
REQ-020 In ACCUM, an accepted sample SHALL set acc = acc + sample mod 2^ACC_WIDTH and increment sample_cnt by 1.
REQ-021 In ACCUM, a carry out of the ACC_WIDTH-bit add SHALL set acc_overflow to 1, and it SHALL stay 1 until the result leaves.
REQ-022 When the accepted sample makes sample_cnt equal COUNT, next state SHALL be HOLD with acc_valid = 1 in the following cycle.
REQ-023 Latency SHALL be 1 cycle from the last accepted sample to acc_valid.
REQ-024 In HOLD, acc_data, acc_overflow and sample_cnt SHALL stay stable while acc_valid && !acc_ready.
REQ-025 In HOLD, acc_valid && acc_ready SHALL move the block to IDLE next cycle with acc_valid = 0.
REQ-026 The block SHALL NOT accept a sample in the cycle a result leaves; the next sample is accepted from IDLE, giving 1 bubble cycle.
REQ-027 In IDLE and ACCUM with in_valid = 0, state, acc and sample_cnt SHALL hold their values.
REQ-028 clear = 1 SHALL move the block to IDLE next cycle from any state, with acc = 0, sample_cnt = 0, acc_overflow = 0 and acc_valid = 0.
REQ-029 clear = 1 SHALL override a same-cycle sample accept and a same-cycle result handshake; the sample is discarded.
REQ-030 acc_data SHALL show the accumulator register in every state; it is meaningful only while acc_valid = 1.

Reset
REQ-031 rst = 1 SHALL set state = IDLE, acc_data = 0, sample_cnt = 0, acc_overflow = 0 and acc_valid = 0 at the next edge.
REQ-032 in_ready SHALL be 1 in the first cycle after rst is released.
REQ-033 rst SHALL take priority over clear and over all handshakes; reset mid-accumulation SHALL discard the partial result.

Structure
REQ-034 Package sum_acc_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and the default parameter constants.
REQ-035 The ACC_WIDTH-bit add SHALL use one adder_cla instance with WIDTH = ACC_WIDTH; its carry_out SHALL drive the overflow logic.
REQ-036 All remaining logic SHALL be a single always_ff and comb next-state logic; there SHALL be no other sub-modules.

Verification (WIDTH=8, ACC_WIDTH=16, COUNT=4 unless stated)
REQ-037 4 back-to-back samples {1, 0xFF} -> acc_valid 1 cycle after the 4th; acc_data = 0x07FC, acc_overflow = 0, sample_cnt = 4.
REQ-038 ACC_WIDTH=10, 4 samples of 0x1FF -> acc_data = 0x3FC (2044 mod 1024), acc_overflow = 1.
REQ-039 Backpressure: acc_ready held 0 for 5 cycles in HOLD -> in_ready = 0 and acc_data stable for all 5; on acc_ready = 1, IDLE next cycle.
REQ-040 clear asserted together with the 3rd valid sample -> sample discarded; then 4 samples of 0x010 -> acc_data = 0x0040.
REQ-041 rst pulsed for 1 cycle after 2 samples -> all outputs 0 and in_ready = 1; the next 4 samples of 0x001 -> acc_data = 0x0004.
REQ-042 COUNT=1, sample 0x155 -> acc_valid next cycle, acc_data = 0x0155, sample_cnt = 1.
